// File: rtl/rv_fifo_if.sv
// Generic valid/ready channel carrying a W-bit payload.
// master drives valid/data, slave drives ready.
interface rv_fifo_if #(
  parameter int W = 32
);
  // A beat transfers on a rising clk edge where valid && ready. Once valid is
  // raised, valid and data hold until that edge. The master never waits on ready.
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rv_fifo.sv
// Parametrised first-word-fall-through ready/valid FIFO with occupancy, almost-full and flush.
// Optional same-cycle bypass when empty: define RV_FIFO_BYPASS_EN.
module rv_fifo #(
  parameter int W         = 32,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  rv_fifo_if.slave                   in_if,
  rv_fifo_if.master                  out_if,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  assign count       = count_q;
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_C);

  // Ready depends only on registered occupancy, never on out_if.ready.
  assign in_if.ready = !full && !rst;

  assign push = in_if.valid && in_if.ready;
  assign pop  = out_if.valid && out_if.ready;

`ifdef RV_FIFO_BYPASS_EN
  logic bypass;

  assign bypass      = empty && in_if.valid && !rst && !flush;
  assign out_if.valid = (!empty && !rst) || bypass;
  assign out_if.data  = empty ? in_if.data : mem[rd_ptr];
  // A word that passes straight through when empty is never stored.
  assign wr_en = push && !(empty && pop);
  assign rd_en = pop && !empty;
`else
  assign out_if.valid = !empty && !rst;
  assign out_if.data  = mem[rd_ptr];
  assign wr_en = push;
  assign rd_en = pop;
`endif

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_fifo.sv
// Directed self-checking bench for rv_fifo (W=8, DEPTH=4, AF_THRESH=3).
// Inputs change and outputs are sampled just after the falling edge.
module tb_rv_fifo;

  localparam int W = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_d;

  rv_fifo_if #(.W(W)) in_if ();
  rv_fifo_if #(.W(W)) out_if ();

  rv_fifo #(.W(W), .DEPTH(DEPTH), .AF_THRESH(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_if       (in_if),
    .out_if      (out_if),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_if.valid  = v;
    in_if.data   = d;
    out_if.ready = r;
    #1;
  endtask

  // pushes with out_ready low; scoreboard records each accepted word
  task automatic fill(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, base + W'(i), 1'b0);
      checks++;
      if (in_if.ready !== 1'b1) begin
        errors++; $display("FAIL fill_ready i=%0d act=%b exp=1", i, in_if.ready);
      end
      exp_q.push_back(base + W'(i));
      tick();
    end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, '0, 1'b1);
      exp_d = exp_q.pop_front();
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== exp_d) begin
        errors++;
        $display("FAIL drain_data i=%0d act v=%b d=%h exp v=1 d=%h", i, out_if.valid, out_if.data, exp_d);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    checks++;
    if (empty !== 1'b1 || out_if.valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty act empty=%b ov=%b cnt=%0d exp 1/0/0", empty, out_if.valid, count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b1, 8'h11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_if.ready !== 1'b0 || out_if.valid !== 1'b0 || count !== 3'd0) begin
        errors++;
        $display("FAIL reset_hold c=%0d act ir=%b ov=%b cnt=%0d exp 0/0/0", i, in_if.ready, out_if.valid, count);
      end
    end
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    checks++;
    if (in_if.ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_release act ir=%b e=%b f=%b af=%b exp 1/1/0/0", in_if.ready, empty, full, almost_full);
    end
    tick();
    checks++;
    if (count !== 3'd0 || out_if.valid !== 1'b0) begin
      errors++; $display("FAIL reset_nodata act cnt=%0d ov=%b exp 0/0", count, out_if.valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA0 + W'(i), 1'b0);
      exp_q.push_back(8'hA0 + W'(i));
      tick();
      checks++;
      if (count !== 3'(i + 1) || almost_full !== (i >= 2)) begin
        errors++;
        $display("FAIL fill_count i=%0d act cnt=%0d af=%b exp cnt=%0d af=%b", i, count, almost_full, i + 1, i >= 2);
      end
    end
    checks++;
    if (full !== 1'b1 || in_if.ready !== 1'b0) begin
      errors++; $display("FAIL fill_full act f=%b ir=%b exp 1/0", full, in_if.ready);
    end
    drive(1'b1, 8'hA4, 1'b0);
    tick();
    checks++;
    if (count !== 3'd4 || out_if.data !== 8'hA0) begin
      errors++; $display("FAIL fill_overflow act cnt=%0d head=%h exp 4/a0", count, out_if.data);
    end
    drain(4);
  endtask

  task automatic test_back_to_back();
    fill(8'hB0, 2);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'hB2 + W'(i), 1'b1);
      exp_d = exp_q.pop_front();
      checks++;
      if (in_if.ready !== 1'b1 || out_if.valid !== 1'b1 || out_if.data !== exp_d) begin
        errors++;
        $display("FAIL stream_beat i=%0d act ir=%b ov=%b d=%h exp 1/1/%h", i, in_if.ready, out_if.valid, out_if.data, exp_d);
      end
      exp_q.push_back(8'hB2 + W'(i));
      tick();
      checks++;
      if (count !== 3'd2) begin
        errors++; $display("FAIL stream_count i=%0d act=%0d exp=2", i, count);
      end
    end
    drain(2);
  endtask

  task automatic test_full_pop();
    fill(8'hC0, 4);
    drive(1'b1, 8'hC4, 1'b1);
    exp_d = exp_q.pop_front();
    checks++;
    if (in_if.ready !== 1'b0 || out_if.data !== exp_d) begin
      errors++; $display("FAIL fullpop_c0 act ir=%b d=%h exp 0/%h", in_if.ready, out_if.data, exp_d);
    end
    tick();
    checks++;
    if (count !== 3'd3 || in_if.ready !== 1'b1) begin
      errors++; $display("FAIL fullpop_c1 act cnt=%0d ir=%b exp 3/1", count, in_if.ready);
    end
    exp_d = exp_q.pop_front();
    checks++;
    if (out_if.data !== exp_d) begin
      errors++; $display("FAIL fullpop_head act=%h exp=%h", out_if.data, exp_d);
    end
    exp_q.push_back(8'hC4);
    tick();
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL fullpop_c2 act=%0d exp=3", count);
    end
    drain(3);
  endtask

  task automatic test_flush();
    fill(8'hD0, 3);
    flush = 1'b1;
    drive(1'b1, 8'hD3, 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0);
    exp_q.delete();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_if.valid !== 1'b0) begin
      errors++; $display("FAIL flush_state act cnt=%0d e=%b ov=%b exp 0/1/0", count, empty, out_if.valid);
    end
    fill(8'hE0, 1);
    drain(1);
  endtask

  task automatic test_reset_mid();
    fill(8'h70, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    exp_q.delete();
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid act cnt=%0d e=%b ov=%b ir=%b exp 0/1/0/1", count, empty, out_if.valid, in_if.ready);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 8'h55, 1'b1);
`ifdef RV_FIFO_BYPASS_EN
    checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'h55) begin
      errors++; $display("FAIL bypass_same act ov=%b d=%h exp 1/55", out_if.valid, out_if.data);
    end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL bypass_count act cnt=%0d e=%b exp 0/1", count, empty);
    end
`else
    checks++;
    if (out_if.valid !== 1'b0) begin
      errors++; $display("FAIL nobypass_same act ov=%b exp 0", out_if.valid);
    end
    tick();
    drive(1'b0, '0, 1'b0);
    checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'h55 || count !== 3'd1) begin
      errors++; $display("FAIL nobypass_next act ov=%b d=%h cnt=%0d exp 1/55/1", out_if.valid, out_if.data, count);
    end
    exp_q.push_back(8'h55);
    drain(1);
`endif
  endtask

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    rst   = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_bypass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
